// File: rtl/uart_img_rx.sv
// UART 8N1 receiver that streams a fixed-size grayscale image into the accelerator,
// one pixel per accepted byte, with framing-error and mid-frame idle-timeout recovery.
module uart_img_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int IMG_PIXELS   = 784,
    parameter int IDLE_TIMEOUT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] img_dout,
    output logic       dout_vld,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int HALF_DIV  = BAUD_DIV / 2;
    localparam int TO_CYCLES = IDLE_TIMEOUT * BAUD_DIV;
    localparam int BW        = $clog2(BAUD_DIV + 1);
    localparam int PW        = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int TW        = $clog2(TO_CYCLES + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF_DIV - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_PIXELS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state_reg;
    logic          rxd_meta_reg;
    logic          rxd_s_reg;
    logic          rxd_prev_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [PW-1:0] pix_cnt_reg;
    logic [TW-1:0] idle_timer_reg;
    logic          start_edge;

    assign start_edge = rxd_prev_reg & ~rxd_s_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            rxd_meta_reg   <= 1'b1;
            rxd_s_reg      <= 1'b1;
            rxd_prev_reg   <= 1'b1;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            pix_cnt_reg    <= '0;
            idle_timer_reg <= '0;
            img_dout       <= '0;
            dout_vld       <= 1'b0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            rxd_meta_reg <= uart_rxd;
            rxd_s_reg    <= rxd_meta_reg;
            rxd_prev_reg <= rxd_s_reg;
            dout_vld     <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= (pix_cnt_reg != '0);

            case (state_reg)
                S_IDLE: begin
                    // A start edge takes priority over an expiring timeout.
                    if (start_edge) begin
                        state_reg      <= S_START;
                        baud_cnt_reg   <= '0;
                        bit_cnt_reg    <= '0;
                        idle_timer_reg <= '0;
                    end else if (pix_cnt_reg == '0) begin
                        idle_timer_reg <= '0;
                    end else if (idle_timer_reg == TO_LAST) begin
                        frame_err      <= 1'b1;
                        pix_cnt_reg    <= '0;
                        idle_timer_reg <= '0;
                    end else begin
                        idle_timer_reg <= idle_timer_reg + 1'b1;
                    end
                end

                S_START: begin
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= rxd_s_reg ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_cnt_reg == BAUD_LAST) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {rxd_s_reg, shift_reg[7:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= S_STOP;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_cnt_reg == BAUD_LAST) begin
                        baud_cnt_reg <= '0;
                        if (rxd_s_reg) begin
                            dout_vld  <= 1'b1;
                            img_dout  <= shift_reg;
                            state_reg <= S_IDLE;
                            if (pix_cnt_reg == PIX_LAST) begin
                                frame_done  <= 1'b1;
                                pix_cnt_reg <= '0;
                            end else begin
                                pix_cnt_reg <= pix_cnt_reg + 1'b1;
                            end
                        end else begin
                            // Bad stop bit: drop the byte and the partial frame.
                            frame_err   <= 1'b1;
                            pix_cnt_reg <= '0;
                            state_reg   <= S_WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                S_WAIT_HIGH: begin
                    if (rxd_s_reg) begin
                        state_reg <= S_IDLE;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_img_rx.sv
// Randomized scoreboard bench for uart_img_rx: a frame-level model predicts pixels,
// frame boundaries and error pulses; a negedge monitor compares what the DUT emits.
module tb_uart_img_rx;

    localparam int CLK_FREQ     = 1_600_000;
    localparam int BAUD         = 100_000;
    localparam int IMG_PIXELS   = 4;
    localparam int IDLE_TIMEOUT = 3;
    localparam int BIT_CYC      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] img_dout;
    logic       dout_vld;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;
    int model_cnt = 0;
    logic [8:0] exp_q[$];

    uart_img_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .IMG_PIXELS  (IMG_PIXELS),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .img_dout  (img_dout),
        .dout_vld  (dout_vld),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pixel the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (dout_vld) begin
                check("err_with_vld", int'(frame_err), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", int'(img_dout), -1);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    $display("rx pixel %02h frame_done=%0b (exp %02h/%0b)", img_dout, frame_done, e[7:0], e[8]);
                    check("pixel_data", int'(img_dout), int'(e[7:0]));
                    check("frame_done", int'(frame_done), int'(e[8]));
                end
            end else if (frame_done) begin
                check("done_without_vld", 1, 0);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void expect_pixel(input logic [7:0] b);
        exp_q.push_back({(model_cnt == IMG_PIXELS - 1), b});
        model_cnt = (model_cnt + 1) % IMG_PIXELS;
    endfunction

    task automatic send_raw(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        expect_pixel(b);
        send_raw(b, 1'b1);
    endtask

    task automatic idle_gap(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic timeout_gap(input int n);
        if (model_cnt != 0) err_exp++;
        model_cnt = 0;
        idle_gap(n);
    endtask

    task automatic bad_stop(input logic [7:0] b, input int hold);
        send_raw(b, 1'b0);
        err_exp++;
        model_cnt = 0;
        uart_rxd = 1'b0;
        repeat (hold) @(negedge clk);
        idle_gap(4);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic checkpoint(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_err_count"}, err_seen, err_exp);
        check({tag, "_busy"}, int'(busy), int'(model_cnt != 0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout"}, int'(img_dout), 0);
        check({tag, "_vld"}, int'(dout_vld), 0);
        check({tag, "_done"}, int'(frame_done), 0);
        check({tag, "_err"}, int'(frame_err), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        logic [7:0] t1 [4];
        t1[0] = 8'h00; t1[1] = 8'hFF; t1[2] = 8'hA5; t1[3] = 8'h3C;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle_gap(10);

        // Single frame, back-to-back bytes.
        send_good(t1[0]);
        checkpoint("t1_first");
        for (int i = 1; i < 4; i++) send_good(t1[i]);
        drain("t1");
        idle_gap(5);
        checkpoint("t1_end");

        // Two frames with no gap.
        for (int i = 0; i < 8; i++) send_good(8'($urandom_range(0, 255)));
        drain("t2");
        idle_gap(5);
        checkpoint("t2_end");

        // Bad stop bit, stuck-low line, then recovery.
        bad_stop(8'h55, 40);
        checkpoint("t3_err");
        send_good(8'h12);
        drain("t3");
        checkpoint("t3_end");

        // Short glitch on an idle line.
        idle_gap(10);
        uart_rxd = 1'b0;
        repeat (6) @(negedge clk);
        idle_gap(40);
        checkpoint("t4_glitch");

        // Mid-frame idle timeout.
        send_good(8'h81);
        send_good(8'h7E);
        drain("t5_pre");
        timeout_gap(70);
        checkpoint("t5_timeout");
        for (int i = 0; i < 4; i++) send_good(8'($urandom_range(0, 255)));
        drain("t5");
        checkpoint("t5_end");

        // Randomized mix of good bytes, short gaps, timeouts and framing errors.
        for (int k = 0; k < 16; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                send_good(8'($urandom_range(0, 255)));
                idle_gap(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 30)));
            end else if (r == 7) begin
                bad_stop(8'($urandom_range(0, 255)), int'($urandom_range(5, 30)));
            end else begin
                send_good(8'($urandom_range(0, 255)));
                timeout_gap(int'($urandom_range(60, 80)));
            end
            checkpoint("rand");
        end
        drain("rand");

        // Reset in the middle of the third byte's data bits.
        send_good(8'hC3);
        send_good(8'h5A);
        drain("t6_pre");
        uart_rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        model_cnt = 0;
        repeat (5) @(negedge clk);
        check_outputs_zero("t6_rst_hold");
        rst_n = 1'b1;
        idle_gap(20);
        for (int i = 0; i < 4; i++) send_good(8'(8'h20 + i));
        drain("t6");
        idle_gap(5);
        checkpoint("t6_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_img_rx.md
# uart_img_rx

UART receiver that accepts a 28x28 8-bit grayscale image from a host PC and streams it pixel-by-pixel into the `mnist` accelerator. It replaces the on-chip `img` ROM source, so new test images need no re-synthesis. It is the inbound counterpart of the `output_send` UART transmitter. It sits between the board RX pin and the `input_vld`/`input_din` port of `mnist`, downstream of `sync_rst`.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. `BAUD_DIV = CLK_FREQ/BAUD` is truncated to an integer; 434 at the defaults.
- `IMG_PIXELS`, 784: number of bytes in one frame.
- `IDLE_TIMEOUT`, 20: number of bit times of idle line mid-frame before the frame is aborted.

Ports:
- `clk`, in, 1: system clock. All logic is clocked on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low. Driven from the `sync_rst` output.
- `uart_rxd`, in, 1: serial line, asynchronous, idles high. Format is 8N1, LSB first.
- `img_dout`, out, 8: received pixel value. Valid only while `dout_vld` is high.
- `dout_vld`, out, 1: one-cycle pulse per accepted pixel.
- `frame_done`, out, 1: one-cycle pulse coincident with the `dout_vld` of pixel `IMG_PIXELS-1`.
- `frame_err`, out, 1: one-cycle pulse on a framing error or an idle timeout.
- `busy`, out, 1: high while the pixel count is non-zero, i.e. a frame is in progress.

## Operation
- `uart_rxd` passes through a 2-FF synchronizer, with both flops resetting to 1. All sampling uses the synchronized value `rxd_s`.
- FSM states:
  - IDLE → START on a falling edge of `rxd_s`. The bit counter clears.
  - START: at `BAUD_DIV/2` cycles after the edge, sample the line.
    - Low → DATA, with the baud counter restarted.
    - High → IDLE (glitch). No output, no error.
  - DATA: sample at each `BAUD_DIV`-cycle boundary, 8 samples total, shifted in LSB first. After bit 7 → STOP.
  - STOP: sample after one further `BAUD_DIV`.
    - High: `dout_vld`=1 and `img_dout`=the shift register for one cycle. Pixel count increments. → IDLE.
    - Low: byte discarded, `frame_err` pulses, pixel count clears to 0. → WAIT_HIGH.
  - WAIT_HIGH → IDLE when `rxd_s`=1. This blocks a false start on a stuck-low line.
- Pixel count range is 0..`IMG_PIXELS-1`.
  - On the accepted byte with count = `IMG_PIXELS-1`, `frame_done` pulses and the count wraps to 0.
  - Back-to-back frames need no gap.
- Idle timeout: in IDLE with count ≠ 0, a timer counts clock cycles.
  - Reaching `IDLE_TIMEOUT*BAUD_DIV` cycles pulses `frame_err` and clears the count.
  - Any start edge clears the timer.
  - With count = 0 the timer is held at 0.
- No backpressure. `mnist` accepts one pixel per cycle, and pixels arrive at most once per 10 bit times.
- `img_dout` holds its last value when `dout_vld`=0.

## Timing
- Reset values: `img_dout`=0, `dout_vld`=0, `frame_done`=0, `frame_err`=0, `busy`=0. State is IDLE, all counters are 0, and the synchronizer flops are 1.
- Asynchronous reset mid-byte or mid-frame aborts immediately. After release the block waits in IDLE for a fresh falling edge. Partial frames are not resumed.
- Latency from the falling edge at the pin to `dout_vld` is 2 + `BAUD_DIV/2` + 9·`BAUD_DIV` + 1 cycles, ±1 cycle of edge-to-clock uncertainty.
- `frame_done` and `dout_vld` are asserted in the same cycle.
- `frame_err` is never coincident with `dout_vld`.
- If a timeout and a start edge land in the same cycle, the start edge wins: no error, timer cleared.
- `busy` is registered and reflects count ≠ 0 one cycle after the count updates.

## Test plan
Simulation parameters: `CLK_FREQ`=1_600_000, `BAUD`=100_000 (`BAUD_DIV`=16), `IMG_PIXELS`=4, `IDLE_TIMEOUT`=3.

1. Bytes 0x00, 0xFF, 0xA5, 0x3C sent back-to-back → four `dout_vld` pulses carrying exactly those values. `frame_done` pulses with the 0x3C pulse. `busy` is high from the first pixel until after the 4th, and 0 afterwards.
2. Two frames of 4 bytes sent with no gap → 8 pulses and 2 `frame_done` pulses. The count wraps cleanly.
3. 0x55 sent with the stop bit driven 0 → no `dout_vld`, one `frame_err` pulse.
   - The line is held low for 40 cycles, then released; no start is detected while it is low.
   - A following 0x12 is received as pixel 0.
4. 6-cycle low glitch on an idle line → no `dout_vld`, no `frame_err`. The state returns to IDLE.
5. 2 bytes sent, then idle for more than 48 cycles → `frame_err` pulses once and `busy` drops. The next 4 bytes form a complete frame with `frame_done`.
6. `rst_n` asserted mid-DATA of the 3rd byte, then 4 bytes sent → all outputs are 0 during reset. The 4 new bytes produce exactly one `frame_done`, on the 4th byte.
